// File: rtl/occupancy_grid_updater_if.sv
// ============================================================================
// Module      : occupancy_grid_updater_if
// Description : Beam request handshake and grid RAM port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface occupancy_grid_updater_if;
    logic        beam_valid;
    logic        beam_ready;
    logic [7:0]  origin_x;
    logic [6:0]  origin_y;
    logic [7:0]  end_x;
    logic [6:0]  end_y;
    logic [14:0] mem_address;
    logic        mem_write_enable;
    logic [7:0]  mem_write_data;
    logic [7:0]  mem_read_data;
    logic        busy;
    logic        done;

    // Design-side view
    modport slave (
        input  beam_valid, origin_x, origin_y, end_x, end_y, mem_read_data,
        output beam_ready, mem_address, mem_write_enable, mem_write_data,
               busy, done
    );

    // Requester / RAM-side view
    modport master (
        output beam_valid, origin_x, origin_y, end_x, end_y, mem_read_data,
        input  beam_ready, mem_address, mem_write_enable, mem_write_data,
               busy, done
    );
endinterface

`default_nettype wire

// File: rtl/occupancy_grid_updater.sv
// ============================================================================
// Module      : occupancy_grid_updater
// Description : Walks a Bresenham beam through a 256x128 grid RAM, decrementing
//               free cells and incrementing the endpoint (read-modify-write).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module occupancy_grid_updater #(
    parameter logic [7:0] OCC_INC  = 8'd20,
    parameter logic [7:0] FREE_DEC = 8'd6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    occupancy_grid_updater_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [7:0]         ex_q, ex_d;
    logic [6:0]         ey_q, ey_d;
    logic signed [9:0]  dx_q, dx_d;
    logic signed [9:0]  dy_q, dy_d;
    logic signed [9:0]  err_q, err_d;
    logic               sx_q, sx_d;   // 1 = step toward decreasing x
    logic               sy_q, sy_d;   // 1 = step toward decreasing y

    logic [7:0]         w_adx;
    logic [6:0]         w_ady;
    logic signed [9:0]  w_dx_init;
    logic signed [9:0]  w_dy_init;
    logic signed [10:0] w_e2;
    logic signed [10:0] w_dx_ext;
    logic signed [10:0] w_dy_ext;
    logic               w_step_x;
    logic               w_step_y;
    logic               w_at_end;
    logic [8:0]         w_inc_sum;
    logic [8:0]         w_dec_diff;
    logic [7:0]         w_inc_val;
    logic [7:0]         w_dec_val;

    logic               w_beam_ready;
    logic [14:0]        w_mem_address;
    logic               w_mem_write_enable;
    logic [7:0]         w_mem_write_data;
    logic               w_busy;
    logic               w_done;

    assign w_adx     = (bus.end_x >= bus.origin_x) ? (bus.end_x - bus.origin_x)
                                                   : (bus.origin_x - bus.end_x);
    assign w_ady     = (bus.end_y >= bus.origin_y) ? (bus.end_y - bus.origin_y)
                                                   : (bus.origin_y - bus.end_y);
    assign w_dx_init = $signed({2'b00, w_adx});
    assign w_dy_init = 10'sd0 - $signed({3'b000, w_ady});

    assign w_e2      = {err_q, 1'b0};
    assign w_dx_ext  = {dx_q[9], dx_q};
    assign w_dy_ext  = {dy_q[9], dy_q};
    assign w_step_x  = (w_e2 >= w_dy_ext);
    assign w_step_y  = (w_e2 <= w_dx_ext);
    assign w_at_end  = (x_q == ex_q) && (y_q == ey_q);

    // Nine-bit arithmetic so saturation is detected from the carry/borrow bit.
    assign w_inc_sum  = {1'b0, bus.mem_read_data} + {1'b0, OCC_INC};
    assign w_dec_diff = {1'b0, bus.mem_read_data} - {1'b0, FREE_DEC};
    assign w_inc_val  = w_inc_sum[8]  ? 8'hFF : w_inc_sum[7:0];
    assign w_dec_val  = w_dec_diff[8] ? 8'h00 : w_dec_diff[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        x_d                = x_q;
        y_d                = y_q;
        ex_d               = ex_q;
        ey_d               = ey_q;
        dx_d               = dx_q;
        dy_d               = dy_q;
        err_d              = err_q;
        sx_d               = sx_q;
        sy_d               = sy_q;
        w_beam_ready       = 1'b0;
        w_mem_address      = '0;
        w_mem_write_enable = 1'b0;
        w_mem_write_data   = '0;
        w_busy             = 1'b0;
        w_done             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_beam_ready = 1'b1;
                if (bus.beam_valid) begin
                    x_d     = bus.origin_x;
                    y_d     = bus.origin_y;
                    ex_d    = bus.end_x;
                    ey_d    = bus.end_y;
                    dx_d    = w_dx_init;
                    dy_d    = w_dy_init;
                    err_d   = w_dx_init + w_dy_init;
                    sx_d    = (bus.end_x < bus.origin_x);
                    sy_d    = (bus.end_y < bus.origin_y);
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                w_busy        = 1'b1;
                w_mem_address = {y_q, x_q};
                state_d       = ST_WRITE;
            end
            ST_WRITE: begin
                w_busy             = 1'b1;
                w_mem_address      = {y_q, x_q};
                w_mem_write_enable = 1'b1;
                if (w_at_end) begin
                    w_mem_write_data = w_inc_val;
                    w_done           = 1'b1;
                    state_d          = ST_IDLE;
                end else begin
                    w_mem_write_data = w_dec_val;
                    // Both tests use the pre-step error term.
                    err_d = err_q + (w_step_x ? dy_q : 10'sd0)
                                  + (w_step_y ? dx_q : 10'sd0);
                    if (w_step_x) x_d = sx_q ? (x_q - 8'd1) : (x_q + 8'd1);
                    if (w_step_y) y_d = sy_q ? (y_q - 7'd1) : (y_q + 7'd1);
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.beam_ready       = w_beam_ready;
    assign bus.mem_address      = w_mem_address;
    assign bus.mem_write_enable = w_mem_write_enable;
    assign bus.mem_write_data   = w_mem_write_data;
    assign bus.busy             = w_busy;
    assign bus.done             = w_done;

endmodule

`default_nettype wire

// File: tb/tb_occupancy_grid_updater.sv
// ============================================================================
// Module      : tb_occupancy_grid_updater
// Description : Self-checking bench with grid RAM model and beam reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_occupancy_grid_updater;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    occupancy_grid_updater_if bus();

    occupancy_grid_updater #(
        .OCC_INC  (8'd20),
        .FREE_DEC (8'd6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] gmem    [0:32767];
    logic [7:0] ref_mem [0:32767];
    logic [7:0] rdata;

    always @(posedge clk) begin
        rdata <= gmem[bus.mem_address];
        if (bus.mem_write_enable === 1'b1)
            gmem[bus.mem_address] <= bus.mem_write_data;
    end
    assign bus.mem_read_data = rdata;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference beam path: plain integer Bresenham from origin to endpoint.
    int px[$];
    int py[$];

    task automatic build_path(input int ox, input int oy, input int ex, input int ey);
        int dx, dy, sx, sy, err, e2, x, y;
        px.delete();
        py.delete();
        dx  = (ex > ox) ? ex - ox : ox - ex;
        dy  = -((ey > oy) ? ey - oy : oy - ey);
        sx  = (ex >= ox) ? 1 : -1;
        sy  = (ey >= oy) ? 1 : -1;
        err = dx + dy;
        x   = ox;
        y   = oy;
        for (int guard = 0; guard < 400; guard++) begin
            px.push_back(x);
            py.push_back(y);
            if (x == ex && y == ey) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    function automatic int cell_update(input int v, input bit is_end);
        if (is_end) return (v + 20 > 255) ? 255 : v + 20;
        return (v - 6 < 0) ? 0 : v - 6;
    endfunction

    // Must be entered while the clock is low (after a negedge).
    task automatic run_beam(input int ox, input int oy, input int ex, input int ey,
                            input bit hold, input int nox, input int noy,
                            input int nex, input int ney, output int cyc);
        int  n, a, e;
        bit  acc, last;
        build_path(ox, oy, ex, ey);
        n = px.size();
        bus.origin_x   = 8'(ox);
        bus.origin_y   = 7'(oy);
        bus.end_x      = 8'(ex);
        bus.end_y      = 7'(ey);
        bus.beam_valid = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < 100; w++) begin
            if (bus.beam_ready === 1'b1) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        cyc = 0;
        if (!acc) begin
            bus.beam_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            bus.origin_x = 8'(nox);
            bus.origin_y = 7'(noy);
            bus.end_x    = 8'(nex);
            bus.end_y    = 7'(ney);
        end else begin
            bus.beam_valid = 1'b0;
        end
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            cyc++;
            if (k < 2 * n) begin
                a = py[k / 2] * 256 + px[k / 2];
                chk("addr", 32'(bus.mem_address), 32'(a));
                chk("ready_while_busy", 32'(bus.beam_ready), 32'd0);
                if (k % 2 == 0) begin
                    chk("read_we", 32'(bus.mem_write_enable), 32'd0);
                    chk("read_wdata", 32'(bus.mem_write_data), 32'd0);
                    chk("read_done", 32'(bus.done), 32'd0);
                end else begin
                    last = (k / 2 == n - 1);
                    e    = cell_update(int'(ref_mem[a]), last);
                    chk("write_we", 32'(bus.mem_write_enable), 32'd1);
                    chk("wdata", 32'(bus.mem_write_data), 32'(e));
                    chk("done", 32'(bus.done), 32'(last));
                    ref_mem[a] = 8'(e);
                end
            end
        end
        chk("beam_cycles", 32'(cyc), 32'(2 * n));
        chk("idle_ready", 32'(bus.beam_ready), 32'd1);
        chk("idle_we", 32'(bus.mem_write_enable), 32'd0);
        chk("idle_wdata", 32'(bus.mem_write_data), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
    endtask

    task automatic preset_path(input int v);
        for (int i = 0; i < px.size(); i++) begin
            gmem[py[i] * 256 + px[i]]    <= 8'(v);
            ref_mem[py[i] * 256 + px[i]] = 8'(v);
        end
    endtask

    typedef struct {
        int ox, oy, ex, ey;
        int init_val;
        int exp_cells;
        int exp_end;
        int exp_free;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         cyc, ea, fa, wcount;
        logic [7:0] rv;

        vecs[0] = '{10,  5,  10, 5, 128,   1, 148, 0};
        vecs[1] = '{0,   0,   3, 0, 128,   4, 148, 122};
        vecs[2] = '{5,  10,   3, 4, 128,   7, 148, 122};
        vecs[3] = '{20, 20,  22, 20, 250,  3, 255, 244};
        vecs[4] = '{30, 30,  30, 33,   3,  4,  23, 0};
        vecs[5] = '{255, 127, 0, 0,  128, 256, 148, 122};

        for (int i = 0; i < 32768; i++) begin
            rv         = 8'($urandom);
            gmem[i]    <= rv;
            ref_mem[i] = rv;
        end

        bus.beam_valid = 1'b0;
        bus.origin_x   = '0;
        bus.origin_y   = '0;
        bus.end_x      = '0;
        bus.end_y      = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.beam_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_we", 32'(bus.mem_write_enable), 32'd0);
        chk("rst_addr", 32'(bus.mem_address), 32'd0);
        chk("rst_wdata", 32'(bus.mem_write_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with independently known results
        for (int v = 0; v < 6; v++) begin
            build_path(vecs[v].ox, vecs[v].oy, vecs[v].ex, vecs[v].ey);
            preset_path(vecs[v].init_val);
            @(negedge clk);
            run_beam(vecs[v].ox, vecs[v].oy, vecs[v].ex, vecs[v].ey, 1'b0, 0, 0, 0, 0, cyc);
            ea = vecs[v].ey * 256 + vecs[v].ex;
            fa = vecs[v].oy * 256 + vecs[v].ox;
            chk("tbl_cycles", 32'(cyc), 32'(2 * vecs[v].exp_cells));
            chk("tbl_end_val", 32'(gmem[ea]), 32'(vecs[v].exp_end));
            if (vecs[v].exp_cells > 1)
                chk("tbl_free_val", 32'(gmem[fa]), 32'(vecs[v].exp_free));
        end

        // Request held during busy with the next beam's coordinates
        run_beam(40, 40, 43, 42, 1'b1, 60, 60, 58, 65, cyc);
        run_beam(60, 60, 58, 65, 1'b0, 0, 0, 0, 0, cyc);

        for (int r = 0; r < 20; r++) begin
            int ox, oy, ex, ey;
            ox = int'($urandom_range(0, 255));
            oy = int'($urandom_range(0, 127));
            if (r % 2 == 0) begin
                ex = int'($urandom_range(0, 255));
                ey = int'($urandom_range(0, 127));
            end else begin
                ex = (ox + int'($urandom_range(0, 8))) % 256;
                ey = (oy + 128 - int'($urandom_range(0, 8))) % 128;
            end
            run_beam(ox, oy, ex, ey, 1'b0, 0, 0, 0, 0, cyc);
        end

        // Reset during the write of the second cell of a 4-cell beam
        build_path(0, 0, 3, 0);
        preset_path(128);
        @(negedge clk);
        bus.origin_x   = 8'd0;
        bus.origin_y   = 7'd0;
        bus.end_x      = 8'd3;
        bus.end_y      = 7'd0;
        bus.beam_valid = 1'b1;
        chk("abort_ready", 32'(bus.beam_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.beam_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_we", 32'(bus.mem_write_enable), 32'd1);
        chk("abort_pre_addr", 32'(bus.mem_address), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(bus.mem_write_enable), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_addr", 32'(bus.mem_address), 32'd0);
        chk("abort_wdata", 32'(bus.mem_write_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(bus.beam_ready), 32'd1);
        wcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_write_enable !== 1'b0) wcount++;
        end
        chk("abort_no_writes", 32'(wcount), 32'd0);
        chk("abort_cell0", 32'(gmem[0]), 32'd122);
        chk("abort_cell1", 32'(gmem[1]), 32'd128);
        chk("abort_cell3", 32'(gmem[3]), 32'd128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/occupancy_grid_updater.md
OCCUPANCY_GRID_UPDATER -- requirements
Module: occupancy_grid_updater

Interface
REQ-001 Parameter OCC_INC, 8'd20, saturating increment applied to the beam endpoint cell.
REQ-002 Parameter FREE_DEC, 8'd6, saturating decrement applied to every traversed non-endpoint cell.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 beam_valid  input  1  beam request present.
REQ-006 beam_ready  output  1  block accepts a beam; high only in IDLE.
REQ-007 origin_x  input  8  robot cell column, sampled on acceptance.
REQ-008 origin_y  input  7  robot cell row, sampled on acceptance.
REQ-009 end_x  input  8  beam endpoint column, sampled on acceptance.
REQ-010 end_y  input  7  beam endpoint row, sampled on acceptance.
REQ-011 mem_address  output  15  grid RAM address = {y[6:0], x[7:0]}.
REQ-012 mem_write_enable  output  1  grid RAM write strobe.
REQ-013 mem_write_data  output  8  updated cell value.
REQ-014 mem_read_data  input  8  grid RAM read data, valid one clock after mem_address is presented.
REQ-015 busy  output  1  high from the cycle after acceptance until the final write completes.
REQ-016 done  output  1  one-cycle pulse coincident with the final write of a beam.

Function
REQ-017 Acceptance SHALL occur on a rising edge with beam_valid && beam_ready; inputs are ignored at all other times.
REQ-018 FSM states: IDLE, READ, WRITE; IDLE->READ on acceptance; READ->WRITE always; WRITE->READ if the current cell is not the endpoint, WRITE->IDLE otherwise.
REQ-019 READ: mem_address = current cell, mem_write_enable = 0.
REQ-020 WRITE: mem_address = current cell (unchanged), mem_write_enable = 1, mem_write_data computed combinationally from mem_read_data.
REQ-021 Endpoint cell update: min(255, value + OCC_INC); all other cells: max(0, value - FREE_DEC); arithmetic in 9 bits, no wrap.
REQ-022 Cells SHALL be visited from origin to endpoint inclusive using integer Bresenham: dx = |ex-ox|, dy = -|ey-oy|, err = dx+dy (10-bit signed), sx/sy = +-1 toward the endpoint.
REQ-023 Step at end of each non-final WRITE: e2 = 2*err; if e2 >= dy then err += dy, x += sx; if e2 <= dx then err += dx, y += sy.
REQ-024 Each beam SHALL visit exactly max(|dx|,|dy|)+1 cells, 2 cycles per cell, with no idle cycles between cells.
REQ-025 origin == endpoint: single cell visited, OCC_INC applied, done after 2 cycles.
REQ-026 beam_ready SHALL return high the cycle after the final WRITE; back-to-back beams therefore have one IDLE cycle between them.
REQ-027 Outside WRITE, mem_write_enable SHALL be 0 and mem_write_data SHALL be 0.

Reset
REQ-028 While reset is high: state IDLE, beam_ready 1, busy 0, done 0, mem_write_enable 0, mem_address 0, mem_write_data 0, all coordinate/error registers 0.
REQ-029 Reset asserted mid-beam SHALL abort it immediately (mem_write_enable drops without waiting for a clock); no further cells of that beam are written after deassertion.

Verification
REQ-030 Origin (10,5), end (10,5), cell 1290 = 128 -> one read of 1290, write 148 to 1290, done with that write, 2 cycles total.
REQ-031 Origin (0,0), end (3,0), all cells 128 -> writes 122 to addresses 0,1,2 then 148 to 3; 8 cycles; done only on last write.
REQ-032 Origin (5,10), end (3,4) -> cells (5,10),(5,9),(4,8),(4,7),(4,6),(3,5),(3,4) in order; 14 cycles; only (3,4) incremented.
REQ-033 Saturation: endpoint cell = 250 -> 255; free cell = 3 -> 0.
REQ-034 beam_valid held high while busy with new coordinates -> not accepted until beam_ready; then accepted with the coordinates present at that edge.
REQ-035 Reset pulsed during WRITE of second cell of a 4-cell beam -> mem_write_enable 0 immediately, beam_ready 1 after deassertion, no writes until a new beam is accepted.
